// File: rtl/add_round_key_acc.sv
// add_round_key_acc: AddRoundKey column accumulator.
// Takes one state column and one round-key word per handshake. Each column is
// either XORed with its key word or passed through unchanged. NCOL consecutive
// columns are packed into one state block, which is offered on a valid/ready
// output with back-pressure.

// One column slice of the block. It is written only when selected, and it
// holds its value between blocks.
module ark_col #(
    parameter int WORD_W = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              i_we,
    input  logic              i_bypass,
    input  logic [WORD_W-1:0] i_col,
    input  logic [WORD_W-1:0] i_key,
    output logic [WORD_W-1:0] o_slice
);
    logic [WORD_W-1:0] r_slice;

    // Store the column either raw or key-mixed. Reset clears the slice.
    always_ff @(posedge clk) begin
        if (reset)
            r_slice <= '0;
        else if (i_we)
            r_slice <= i_bypass ? i_col : (i_col ^ i_key);
    end

    assign o_slice = r_slice;
endmodule

module add_round_key_acc #(
    parameter int WORD_W = 32,
    parameter int NCOL   = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [WORD_W-1:0]        in_col,
    input  logic [WORD_W-1:0]        in_key,
    input  logic                     in_bypass,
    input  logic                     abort,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [NCOL*WORD_W-1:0]   out_block,
    output logic [((NCOL > 1) ? $clog2(NCOL) : 1)-1:0] col_idx
);
    localparam int IDX_W = (NCOL > 1) ? $clog2(NCOL) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NCOL - 1);

    typedef enum logic {
        S_FILL = 1'b0,
        S_FULL = 1'b1
    } state_t;

    state_t            r_state;
    state_t            w_state_nxt;
    logic [IDX_W-1:0]  r_idx;
    logic [IDX_W-1:0]  w_idx_nxt;
    logic              w_full;
    logic              w_accept;
    logic              w_xfer;
    logic              w_last;
    logic [NCOL-1:0]   w_we;
    // Element NCOL-1 holds column 0, so the packed array maps directly onto
    // out_block with column 0 in the most significant slice.
    logic [NCOL-1:0][WORD_W-1:0] w_slices;

    assign w_full = (r_state == S_FULL);
    // in_ready depends on out_ready only while a block is held. A new column
    // may be accepted on the same edge that hands the held block over.
    assign in_ready  = w_full ? out_ready : 1'b1;
    assign out_valid = w_full;
    // abort cancels both handshakes in the cycle where it is asserted.
    assign w_accept  = in_valid && in_ready && !abort;
    assign w_xfer    = w_full && out_ready && !abort;
    assign w_last    = (r_idx == LAST_IDX);

    // State and column index registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_FILL;
            r_idx   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_idx   <= w_idx_nxt;
        end
    end

    // Next state and next index. In FULL the index is always 0, so an accept
    // there writes column 0, and the same rule covers streaming.
    always_comb begin
        w_state_nxt = r_state;
        w_idx_nxt   = r_idx;
        if (abort) begin
            w_state_nxt = S_FILL;
            w_idx_nxt   = '0;
        end else if (w_accept) begin
            w_idx_nxt   = w_last ? '0 : r_idx + IDX_W'(1);
            w_state_nxt = w_last ? S_FULL : S_FILL;
        end else if (w_xfer) begin
            w_state_nxt = S_FILL;
        end
    end

    // One slice register per column. Column k lives in element NCOL-1-k.
    for (genvar j = 0; j < NCOL; j++) begin : g_col
        assign w_we[j] = w_accept && (r_idx == IDX_W'(NCOL - 1 - j));

        ark_col #(.WORD_W(WORD_W)) u_col (
            .clk      (clk),
            .reset    (reset),
            .i_we     (w_we[j]),
            .i_bypass (in_bypass),
            .i_col    (in_col),
            .i_key    (in_key),
            .o_slice  (w_slices[j])
        );
    end

    assign out_block = w_slices;
    assign col_idx   = r_idx;
endmodule

// File: tb/tb_add_round_key_acc.sv
// Directed testbench for add_round_key_acc.
// Covers a NCOL=4/WORD_W=32 instance (FIPS-197 round 0, bypass, back-pressure,
// streaming, abort, reset) and a NCOL=1/WORD_W=8 instance.
module tb_add_round_key_acc;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         reset;
    // 4 x 32 instance
    logic         a_in_valid, a_in_ready, a_in_bypass, a_abort, a_out_valid, a_out_ready;
    logic [31:0]  a_in_col, a_in_key;
    logic [127:0] a_out_block;
    logic [1:0]   a_col_idx;
    // 1 x 8 instance
    logic         b_in_valid, b_in_ready, b_in_bypass, b_abort, b_out_valid, b_out_ready;
    logic [7:0]   b_in_col, b_in_key;
    logic [7:0]   b_out_block;
    logic [0:0]   b_col_idx;

    int n_assert = 0;
    int n_fail   = 0;

    add_round_key_acc #(.WORD_W(32), .NCOL(4)) u_a (
        .clk(clk), .reset(reset),
        .in_valid(a_in_valid), .in_ready(a_in_ready),
        .in_col(a_in_col), .in_key(a_in_key), .in_bypass(a_in_bypass),
        .abort(a_abort),
        .out_valid(a_out_valid), .out_ready(a_out_ready),
        .out_block(a_out_block), .col_idx(a_col_idx)
    );

    add_round_key_acc #(.WORD_W(8), .NCOL(1)) u_b (
        .clk(clk), .reset(reset),
        .in_valid(b_in_valid), .in_ready(b_in_ready),
        .in_col(b_in_col), .in_key(b_in_key), .in_bypass(b_in_bypass),
        .abort(b_abort),
        .out_valid(b_out_valid), .out_ready(b_out_ready),
        .out_block(b_out_block), .col_idx(b_col_idx)
    );

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Advance one rising edge, then settle away from it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_a(input logic v, input logic [31:0] c, input logic [31:0] k, input logic byp);
        a_in_valid  = v;
        a_in_col    = c;
        a_in_key    = k;
        a_in_bypass = byp;
    endtask

    localparam logic [31:0] FC0 = 32'h3243f6a8, FC1 = 32'h885a308d,
                            FC2 = 32'h313198a2, FC3 = 32'he0370734;
    localparam logic [31:0] FK0 = 32'h2b7e1516, FK1 = 32'h28aed2a6,
                            FK2 = 32'habf71588, FK3 = 32'h09cf4f3c;
    localparam logic [127:0] FIPS_BLK = 128'h193de3be_a0f4e22b_9ac68d2a_e9f84808;
    localparam logic [127:0] BYP_BLK  = 128'h193de3be_885a308d_9ac68d2a_e0370734;

    initial begin
        logic [127:0] exp_blk;
        logic [31:0]  sc, sk;
        int           pulses;

        reset = 1'b1;
        drive_a(1'b0, '0, '0, 1'b0);
        a_abort = 1'b0; a_out_ready = 1'b0;
        b_in_valid = 1'b0; b_in_col = '0; b_in_key = '0; b_in_bypass = 1'b0;
        b_abort = 1'b0; b_out_ready = 1'b0;
        step(); step();
        reset = 1'b0;
        step();

        // Reset state
        chk("rst_valid", 128'(a_out_valid), 128'(0));
        chk("rst_idx",   128'(a_col_idx),   128'(0));
        chk("rst_block", a_out_block,       128'(0));
        chk("rst_ready", 128'(a_in_ready),  128'(1));

        // FIPS-197 round 0, back-to-back, out_ready low
        drive_a(1'b1, FC0, FK0, 1'b0); step();
        chk("fips_idx1", 128'(a_col_idx), 128'(1));
        drive_a(1'b1, FC1, FK1, 1'b0); step();
        chk("fips_idx2", 128'(a_col_idx), 128'(2));
        drive_a(1'b1, FC2, FK2, 1'b0); step();
        chk("fips_valid_early", 128'(a_out_valid), 128'(0));
        drive_a(1'b1, FC3, FK3, 1'b0); step();
        chk("fips_valid", 128'(a_out_valid), 128'(1));
        chk("fips_block", a_out_block, FIPS_BLK);
        chk("fips_idx0",  128'(a_col_idx), 128'(0));

        // Back-pressure: in_valid held with junk data, nothing may be written
        drive_a(1'b1, 32'hdeadbeef, 32'h01234567, 1'b0);
        for (int i = 0; i < 5; i++) begin
            chk("bp_ready", 128'(a_in_ready),  128'(0));
            chk("bp_valid", 128'(a_out_valid), 128'(1));
            step();
            chk("bp_block", a_out_block, FIPS_BLK);
            chk("bp_idx",   128'(a_col_idx), 128'(0));
        end

        // Raise out_ready with column 0 offered: transfer and accept on one edge
        a_out_ready = 1'b1;
        drive_a(1'b1, FC0, FK0, 1'b0);
        #1;
        chk("bp_ready_comb", 128'(a_in_ready), 128'(1));
        step();
        chk("bp_xfer_valid", 128'(a_out_valid), 128'(0));
        chk("bp_xfer_idx",   128'(a_col_idx),   128'(1));
        chk("bp_xfer_col0",  128'(a_out_block[127:96]), 128'(32'h193de3be));

        // Bypass on columns 1 and 3 completes this block
        drive_a(1'b1, FC1, FK1, 1'b1); step();
        drive_a(1'b1, FC2, FK2, 1'b0); step();
        drive_a(1'b1, FC3, FK3, 1'b1); step();
        chk("byp_valid", 128'(a_out_valid), 128'(1));
        chk("byp_block", a_out_block, BYP_BLK);

        // Streaming: 3 blocks with in_valid = out_ready = 1 throughout
        pulses  = 0;
        exp_blk = '0;
        for (int i = 0; i < 12; i++) begin
            sc = {8'ha0 + 8'(i / 4), 8'h50 + 8'(i % 4), 16'h1234};
            sk = 32'h0f0f0f0f ^ 32'(i);
            drive_a(1'b1, sc, sk, 1'b0);
            step();
            exp_blk[(3 - (i % 4)) * 32 +: 32] = sc ^ sk;
            chk("strm_valid", 128'(a_out_valid), 128'((i % 4) == 3));
            if (a_out_valid) pulses++;
            if ((i % 4) == 3) chk("strm_block", a_out_block, exp_blk);
        end
        chk("strm_pulses", 128'(pulses), 128'(3));
        drive_a(1'b0, '0, '0, 1'b0);
        step();
        chk("strm_drain_valid", 128'(a_out_valid), 128'(0));
        chk("strm_drain_idx",   128'(a_col_idx),   128'(0));

        // Abort after two columns, with a column also offered
        drive_a(1'b1, 32'h11111111, 32'h0, 1'b0); step();
        drive_a(1'b1, 32'h22222222, 32'h0, 1'b0); step();
        chk("abort_pre_idx", 128'(a_col_idx), 128'(2));
        a_abort = 1'b1;
        drive_a(1'b1, 32'h33333333, 32'h0, 1'b0); step();
        a_abort = 1'b0;
        chk("abort_idx",   128'(a_col_idx),   128'(0));
        chk("abort_valid", 128'(a_out_valid), 128'(0));
        a_out_ready = 1'b0;
        drive_a(1'b1, FC0, FK0, 1'b0); step();
        drive_a(1'b1, FC1, FK1, 1'b0); step();
        drive_a(1'b1, FC2, FK2, 1'b0); step();
        drive_a(1'b1, FC3, FK3, 1'b0); step();
        drive_a(1'b0, '0, '0, 1'b0);
        chk("abort_new_valid", 128'(a_out_valid), 128'(1));
        chk("abort_new_block", a_out_block, FIPS_BLK);

        // Abort while FULL with out_ready high: block dropped, nothing written
        a_abort = 1'b1; a_out_ready = 1'b1;
        drive_a(1'b1, 32'h44444444, 32'h0, 1'b0);
        step();
        a_abort = 1'b0; a_out_ready = 1'b0;
        drive_a(1'b0, '0, '0, 1'b0);
        chk("abort_full_valid", 128'(a_out_valid), 128'(0));
        chk("abort_full_idx",   128'(a_col_idx),   128'(0));
        chk("abort_full_ready", 128'(a_in_ready),  128'(1));
        chk("abort_full_block", a_out_block, FIPS_BLK);

        // Reset mid-block
        drive_a(1'b1, FC0, FK0, 1'b0); step();
        drive_a(1'b1, FC1, FK1, 1'b0); step();
        drive_a(1'b0, '0, '0, 1'b0);
        reset = 1'b1; step();
        reset = 1'b0;
        chk("mid_rst_block", a_out_block, 128'(0));
        chk("mid_rst_idx",   128'(a_col_idx),   128'(0));
        chk("mid_rst_valid", 128'(a_out_valid), 128'(0));

        // NCOL=1, WORD_W=8 instance
        chk("b_rst_block", 128'(b_out_block), 128'(0));
        chk("b_rst_idx",   128'(b_col_idx),   128'(0));
        b_out_ready = 1'b1;
        b_in_valid = 1'b1; b_in_col = 8'ha5; b_in_key = 8'h0f; b_in_bypass = 1'b0;
        step();
        chk("b_valid1", 128'(b_out_valid), 128'(1));
        chk("b_block1", 128'(b_out_block), 128'(8'haa));
        chk("b_ready1", 128'(b_in_ready),  128'(1));
        step();
        chk("b_valid2", 128'(b_out_valid), 128'(1));
        chk("b_block2", 128'(b_out_block), 128'(8'haa));
        b_in_bypass = 1'b1;
        step();
        chk("b_byp_block", 128'(b_out_block), 128'(8'ha5));
        b_in_valid = 1'b0;
        step();
        chk("b_drain_valid", 128'(b_out_valid), 128'(0));

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule

// File: doc/add_round_key_acc.md
# add_round_key_acc

Parametrised AddRoundKey column accumulator for the compact AES datapath. Accepts one state column and one round-key word per handshake, XORs them (or passes the column through in bypass mode), and packs NCOL consecutive results into a full state block. It presents the block on a valid/ready output with back-pressure. It sits between the column-serial mix/substitute stages and the next-round state register, and supersedes the fixed 4×32-bit, index-addressed XOR stage.

## Interface
- WORD_W, 32: width of one column and one key word in bits; ≥ 8.
- NCOL, 4: columns per block; ≥ 1.
- clk  in  1  clock; all state updates on rising edge.
- reset  in  1  reset, synchronous, active-high.
- in_valid  in  1  column/key pair offered.
- in_ready  out  1  block can accept a column this cycle.
- in_col  in  WORD_W  state column.
- in_key  in  WORD_W  round-key word.
- in_bypass  in  1  1 stores in_col unmodified; 0 stores in_col ^ in_key. Sampled per column.
- abort  in  1  discard the partial or held block and restart at column 0.
- out_valid  out  1  out_block holds a complete block.
- out_ready  in  1  consumer takes the block.
- out_block  out  NCOL*WORD_W  packed block; column 0 occupies the MS slice, column NCOL-1 the LS slice.
- col_idx  out  max(1,clog2(NCOL))  index of the next column to be written.

## Operation
- Input handshake: a column is accepted on a rising edge with in_valid && in_ready && !abort.
- Output handshake: a block is taken on a rising edge with out_valid && out_ready.
- Two states:
  - FILL: out_valid=0, in_ready=1.
  - FULL: out_valid=1, in_ready=out_ready.
- Accepted column k: slice [(NCOL-k)*WORD_W-1 : (NCOL-1-k)*WORD_W] <= in_bypass ? in_col : in_col ^ in_key. Other slices hold.
- col_idx increments on each accepted column and wraps NCOL-1 -> 0. Accepting column NCOL-1 moves FILL -> FULL.
- In FULL, a transfer with no simultaneous accept moves to FILL.
- In FULL, a transfer with a simultaneous accept writes column 0 and stays in FILL with col_idx=1 (or stays FULL if NCOL=1). This gives zero-bubble streaming.
- Slices are not cleared between blocks. out_block is meaningful only while out_valid=1.
- abort, from any state: next state FILL, col_idx=0, out_valid=0, no slice written. It takes priority over both handshakes in the same cycle. The held block is lost and not counted as transferred.
- in_col, in_key and in_bypass are don't-care when no accept occurs.
- The XOR is bitwise over WORD_W with no carries. Values never widen.

## Timing
- Reset values: out_block=0, out_valid=0, col_idx=0, state FILL, so in_ready=1 in the first cycle after reset.
- Reset overrides abort and both handshakes. Reset mid-block discards all partial data.
- Latency: out_valid rises in the cycle after the edge that accepts column NCOL-1. out_block is stable from that cycle until the transfer edge.
- Throughput: one column per cycle. With out_ready held at 1, one block per NCOL cycles and no idle cycles.
- in_ready depends combinationally on out_ready only in FULL. There is no other combinational input-to-output path.
- out_ready=0 while FULL stalls the input. in_ready=0 and the block is held indefinitely.

## Test plan
- FIPS-197 round 0, NCOL=4, WORD_W=32. Columns 3243f6a8, 885a308d, 313198a2, e0370734 with keys 2b7e1516, 28aed2a6, abf71588, 09cf4f3c, on back-to-back cycles. Required: out_valid one cycle after the 4th accept, and out_block = 193de3be_a0f4e22b_9ac68d2a_e9f84808.
- Bypass: the same stimulus with in_bypass=1 on columns 1 and 3. Required: out_block = 193de3be_885a308d_9ac68d2a_e0370734.
- Back-pressure: out_ready=0 for 5 cycles after FULL. Required: in_ready=0, out_block unchanged, no column written. Then raise out_ready together with in_valid. Required: transfer and column-0 accept on the same edge, and col_idx=1 afterwards.
- Streaming: 3 blocks with in_valid=out_ready=1 throughout. Required: out_valid pulses exactly every 4th cycle, with no dropped or duplicated column.
- Abort: abort after 2 accepted columns. Required: col_idx=0 and out_valid=0. Four new columns then produce a block built only from the new data. Abort while FULL with out_ready=1 must produce no transfer.
- Reset mid-block, plus a NCOL=1, WORD_W=8 instance. After reset: out_block=0, col_idx=0. Each accept of col a5 with key 0f yields out_block=aa with out_valid high the next cycle.
